// File: rtl/serializer_fmt_pkg.sv
// Shared types and helpers for the parallel-to-serial formatter.
package serializer_fmt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  localparam int unsigned GapCntW = 4;
  localparam bit IdleLevelDefault = 1'b0;

  // Bit counter must hold the full word length, hence WIDTH+1.
  function automatic int unsigned bitcnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serializer_fmt_if.sv
// Word-in / bit-out bus between a producer and the serializer.
interface serializer_fmt_if #(
  parameter int unsigned WIDTH = 6
);
  logic             en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output en, in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  en, in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/serializer_fmt_shreg.sv
// Loadable shift register; the head bit is the next bit to leave the word.
module serializer_fmt_shreg #(
  parameter int unsigned WIDTH     = 6,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             head,
  output logic             head_next
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register contents: load wins over shift.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = din;
    end else if (shift) begin
      q_d = MSB_FIRST ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};
    end
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // head_next lets the parent register ser_out without an extra cycle.
  always_comb begin
    head      = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
    head_next = MSB_FIRST ? q_d[WIDTH-1] : q_d[0];
  end

endmodule

// File: rtl/serializer_fmt.sv
// Parallel-to-serial formatter: accepts a word on valid/ready, emits one bit per en tick.
module serializer_fmt
  import serializer_fmt_pkg::*;
#(
  parameter int unsigned WIDTH      = 6,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = IdleLevelDefault,
  parameter int unsigned GAP        = 0
) (
  input logic             clk,
  input logic             rst,
  serializer_fmt_if.slave bus
);

  localparam int unsigned BitcntW = bitcnt_w(WIDTH);
  localparam logic [BitcntW-1:0] CntFull = BitcntW'(WIDTH);
  localparam logic [BitcntW-1:0] CntOne  = BitcntW'(1);
  localparam logic [GapCntW-1:0] GapFull = GapCntW'(GAP);
  localparam logic [GapCntW-1:0] GapOne  = GapCntW'(1);

  state_e             state_q, state_d;
  logic [BitcntW-1:0] cnt_q, cnt_d;
  logic [GapCntW-1:0] gap_q, gap_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_last_q, ser_last_d;

  logic load, shift, accept, in_ready;
  logic head, head_next;

  serializer_fmt_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .din      (bus.in_data),
    .head     (head),
    .head_next(head_next)
  );

  // Ready in idle, or on the final bit when no gap is configured (back-to-back words).
  always_comb begin
    in_ready = (state_q == StIdle) ||
               ((state_q == StShift) && (cnt_q == CntOne) && bus.en && (GAP == 0));
    accept   = bus.in_valid && in_ready;
  end

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = CntFull;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.en) begin
          if (cnt_q == CntOne) begin
            if (accept) begin
              load  = 1'b1;
              cnt_d = CntFull;
            end else begin
              cnt_d = '0;
              if (GAP > 0) begin
                gap_d   = GapFull;
                state_d = StGap;
              end else begin
                state_d = StIdle;
              end
            end
          end else begin
            shift = 1'b1;
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      StGap: begin
        if (bus.en) begin
          gap_d = gap_q - GapOne;
          if (gap_q == GapOne) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ser_valid_d = (state_d == StShift);
    ser_out_d   = ser_valid_d ? head_next : IDLE_LEVEL;
    ser_last_d  = ser_valid_d && (cnt_d == CntOne);
  end

  // State, counters and output registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      gap_q       <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  // Drive the bus; head is kept for observation only through ser_out.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.ser_out   = ser_out_q;
    bus.ser_valid = ser_valid_q;
    bus.ser_last  = ser_last_q;
    bus.busy      = (state_q != StIdle);
  end

  logic unused_head;
  assign unused_head = head;

endmodule

// File: tb/tb_serializer_fmt.sv
// Directed bench: three serializer variants driven by shared stimulus.
module tb_serializer_fmt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [5:0] in_data = '0;
  logic       in_valid = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serializer_fmt_if #(.WIDTH(6)) ifa ();
  serializer_fmt_if #(.WIDTH(6)) ifb ();
  serializer_fmt_if #(.WIDTH(6)) ifc ();

  assign ifa.en = en;
  assign ifa.in_data = in_data;
  assign ifa.in_valid = in_valid;
  assign ifb.en = en;
  assign ifb.in_data = in_data;
  assign ifb.in_valid = in_valid;
  assign ifc.en = en;
  assign ifc.in_data = in_data;
  assign ifc.in_valid = in_valid;

  serializer_fmt #(.WIDTH(6), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  serializer_fmt #(.WIDTH(6), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  serializer_fmt #(.WIDTH(6), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP(2)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [5:0] w1;
    logic [5:0] w2;
    int idx;

    // Reset state.
    do_reset();
    check_eq("rst_ser_out", ifa.ser_out, 0);
    check_eq("rst_ser_valid", ifa.ser_valid, 0);
    check_eq("rst_ser_last", ifa.ser_last, 0);
    check_eq("rst_busy", ifa.busy, 0);
    check_eq("rst_in_ready", ifa.in_ready, 1);

    // MSB-first on A and LSB-first on B, en held high.
    w1 = 6'b101100;
    en = 1'b1;
    in_data = w1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("msb_bit", ifa.ser_out, w1[5-i]);
      check_eq("msb_valid", ifa.ser_valid, 1);
      check_eq("msb_last", ifa.ser_last, (i == 5));
      check_eq("msb_ready", ifa.in_ready, (i == 5));
      check_eq("lsb_bit", ifb.ser_out, w1[i]);
      check_eq("lsb_valid", ifb.ser_valid, 1);
      tick();
    end
    check_eq("msb_end_out", ifa.ser_out, 0);
    check_eq("msb_end_busy", ifa.busy, 0);
    check_eq("msb_end_ready", ifa.in_ready, 1);
    check_eq("lsb_end_valid", ifb.ser_valid, 0);

    // en pulsed every third cycle: each bit held three cycles.
    do_reset();
    w1 = 6'b110001;
    in_data = w1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 18; c++) begin
      en = ((c % 3) == 2);
      check_eq("slow_bit", ifa.ser_out, w1[5-idx]);
      check_eq("slow_busy", ifa.busy, 1);
      check_eq("slow_last", ifa.ser_last, (idx == 5));
      tick();
      if (en) idx++;
    end
    en = 1'b0;
    check_eq("slow_end_busy", ifa.busy, 0);
    check_eq("slow_end_valid", ifa.ser_valid, 0);

    // Back-to-back words with no gap; in_data changed after accept.
    do_reset();
    w1 = 6'h2A;
    w2 = 6'h15;
    en = 1'b1;
    in_data = w1;
    in_valid = 1'b1;
    tick();
    in_data = w2;
    for (int i = 0; i < 12; i++) begin
      check_eq("b2b_bit", ifa.ser_out, (i < 6) ? w1[5-i] : w2[11-i]);
      check_eq("b2b_valid", ifa.ser_valid, 1);
      check_eq("b2b_ready", ifa.in_ready, (i == 5 || i == 11));
      check_eq("b2b_last", ifa.ser_last, (i == 5 || i == 11));
      if (i == 6) in_valid = 1'b0;
      tick();
    end
    check_eq("b2b_end_valid", ifa.ser_valid, 0);
    check_eq("b2b_end_busy", ifa.busy, 0);

    // Two-tick gap between queued words on C.
    do_reset();
    en = 1'b1;
    in_data = w1;
    in_valid = 1'b1;
    tick();
    in_data = w2;
    for (int i = 0; i < 6; i++) begin
      check_eq("gap_w1_bit", ifc.ser_out, w1[5-i]);
      check_eq("gap_w1_ready", ifc.in_ready, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check_eq("gap_out", ifc.ser_out, 0);
      check_eq("gap_valid", ifc.ser_valid, 0);
      check_eq("gap_ready", ifc.in_ready, 0);
      check_eq("gap_busy", ifc.busy, 1);
      tick();
    end
    check_eq("gap_idle_ready", ifc.in_ready, 1);
    check_eq("gap_idle_busy", ifc.busy, 0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("gap_w2_bit", ifc.ser_out, w2[5-i]);
      check_eq("gap_w2_valid", ifc.ser_valid, 1);
      tick();
    end
    check_eq("gap_end_valid", ifc.ser_valid, 0);

    // Reset mid-word, then a clean new word.
    do_reset();
    en = 1'b1;
    in_data = 6'b111111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("pre_rst_bit", ifa.ser_out, 1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_out", ifa.ser_out, 0);
    check_eq("mid_rst_valid", ifa.ser_valid, 0);
    check_eq("mid_rst_busy", ifa.busy, 0);
    w1 = 6'b000001;
    in_data = w1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("post_rst_bit", ifa.ser_out, w1[5-i]);
      check_eq("post_rst_last", ifa.ser_last, (i == 5));
      tick();
    end
    check_eq("post_rst_end", ifa.ser_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_fmt.md
Name: serializer_fmt

Overview:
Parametrised parallel-to-serial formatter, successor to the fixed 6-bit shift-out block. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enable tick. Bit order is selectable, idle level is configurable, and an optional inter-word gap is supported. Sits between a word producer (FSM/FIFO) and any serial line driver paced by a baud/strobe tick.

Parameters:
WIDTH, 6, data word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first
IDLE_LEVEL, 0, ser_out value when no word is being shifted
GAP, 0, number of enable ticks of idle level inserted after each word (0..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  shift tick; one bit consumed per cycle with en=1
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial bit, registered
ser_valid  output  1  ser_out carries a data bit
ser_last  output  1  ser_out is the final bit of the word
busy  output  1  state != IDLE

Behaviour:
- Reset: the sampled rst=1 takes priority over everything. After reset: state IDLE, shift register 0, bit counter 0, gap counter 0, ser_out=IDLE_LEVEL, ser_valid=0, ser_last=0, busy=0.
- A reset arriving mid-word or mid-gap discards that word. No partial bits follow. The next accepted word starts cleanly.
- States: IDLE, SHIFT, GAP.
- Counter widths: bit counter is $clog2(WIDTH+1) bits; gap counter is 4 bits.
- Accept: a word is taken on a posedge where in_valid && in_ready. The shift register loads in_data, the bit counter loads WIDTH, and the state goes to SHIFT.
- Latency: the first bit appears on ser_out in the cycle after acceptance. It does not wait for en.
- SHIFT state:
  - ser_valid=1.
  - ser_out = current head bit: MSB if MSB_FIRST, else LSB.
  - ser_last=1 while bit counter==1.
  - On en=1: the register shifts toward the head, the counter decrements, and the next bit appears the following cycle.
  - On en=0: everything holds, and the bit stays stable for any number of cycles.
- End of word is the cycle with en=1 && counter==1:
  - GAP>0: go to GAP with gap counter=GAP, ser_out=IDLE_LEVEL, ser_valid=0.
  - GAP==0: go to IDLE, unless a new word is accepted in the same cycle (see in_ready).
- GAP state: the gap counter decrements on each en=1. When it reaches 0 the state goes to IDLE. in_ready=0 throughout.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when counter==1 && en=1 && GAP==0, giving back-to-back words with no idle bit.
  - 0 otherwise.
- Simultaneous last-bit and accept: the new word loads and the state stays SHIFT. The new word's head bit appears next cycle, with ser_valid held high and no bubble.
- in_valid while not ready: ignored. The producer must hold in_data/in_valid, and no data is lost.
- in_data is sampled only on the accept edge. Later changes do not affect the word in flight.
- WIDTH bits are emitted exactly. No start or stop bits; framing belongs to a wrapper.

Decomposition:
- Shared package serial_pkg holds:
  - state enum {IDLE, SHIFT, GAP}.
  - function bitcnt_w(WIDTH) returning $clog2(WIDTH+1).
  - IDLE_LEVEL default constant.
- One natural sub-module, serializer_shreg: a WIDTH-bit loadable shift register with a direction parameter, providing load/shift/head outputs.
- The FSM and counters stay in serializer_fmt.

Test Plan:
- WIDTH=6, MSB_FIRST=1, en=1 constant, accept in_data=6'b101100 -> ser_out=1,0,1,1,0,0 on cycles 1..6 after accept. ser_last only on cycle 6. Then ser_out=0, busy=0, in_ready=1.
- Same word with MSB_FIRST=0 -> ser_out=0,0,1,1,0,1. ser_valid high exactly 6 cycles.
- en pulsed every 3rd cycle, word 6'b110001 -> each bit held 3 cycles, order 1,1,0,0,0,1. busy stays high until the 6th en tick.
- GAP=0, in_valid held high with words 6'h2A then 6'h15 -> 12 consecutive ser_valid cycles with no bubble. in_ready high only in IDLE and on the last-bit cycle.
- GAP=2, two queued words -> 6 data bits, then 2 en ticks of IDLE_LEVEL with ser_valid=0 and in_ready=0, then the second word.
- Reset asserted after the 3rd bit of 6'b111111 -> next cycle ser_out=IDLE_LEVEL and ser_valid=0. A following accept of 6'b000001 emits 0,0,0,0,0,1 with no residue.
